// File: rtl/fmul_result_stage.sv
// Registered 2-entry output FIFO behind the FP32 multiplier, with result classification and a delivered-result counter.
// Optional sticky class flags are built when FMUL_STICKY_FLAGS_EN is defined.
module fmul_result_stage #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [4:0]       out_class,
  output logic [CNT_W-1:0] res_count,
  output logic [3:0]       flags,
  input  logic             flag_clr
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OCC_W  = 2;

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [OCC_W-1:0]  count;
  logic [OCC_W-1:0]  count_next_c;
  logic              push_c;
  logic              pop_c;
  logic [7:0]        exp_c;
  logic [22:0]       frac_c;

  assign push_c = in_valid & in_ready;
  assign pop_c  = out_valid & out_ready;

  // Occupancy update; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next_c = count;
    case ({push_c, pop_c})
      2'b10:   count_next_c = count + OCC_W'(1);
      2'b01:   count_next_c = count - OCC_W'(1);
      default: count_next_c = count;
    endcase
  end

  // Storage, pointers and handshake flags; in_ready/out_valid come from next occupancy only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      res_count <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= in_op;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_c) begin
        rd_ptr    <= ~rd_ptr;
        res_count <= res_count + CNT_W'(1);
      end
      count     <= count_next_c;
      out_valid <= (count_next_c != '0);
      in_ready  <= (count_next_c != OCC_W'(DEPTH));
    end
  end

  assign out_data = mem[rd_ptr];
  assign exp_c    = out_data[30:23];
  assign frac_c   = out_data[22:0];

  // One-hot {nan, inf, normal, denorm, zero}; an empty FIFO reports zero.
  always_comb begin
    out_class = 5'b00001;
    if (out_valid) begin
      if (exp_c == 8'hFF) begin
        out_class = (frac_c == '0) ? 5'b01000 : 5'b10000;
      end else if (exp_c == 8'h00) begin
        out_class = (frac_c == '0) ? 5'b00001 : 5'b00010;
      end else begin
        out_class = 5'b00100;
      end
    end
  end

`ifdef FMUL_STICKY_FLAGS_EN
  // Sticky {nan, inf, denorm, zero}; a clear in the same cycle as a pop drops that pop's class.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
    end else if (flag_clr) begin
      flags <= '0;
    end else if (pop_c) begin
      flags <= flags | {out_class[4], out_class[3], out_class[1], out_class[0]};
    end
  end
`else
  logic unused_flag_clr;
  assign unused_flag_clr = flag_clr;
  assign flags           = 4'b0000;
`endif

endmodule

// File: doc/fmul_result_stage.md
Name: fmul_result_stage

Overview:
- Registered output stage directly downstream of the combinational FP32 multiplier `multi`.
- Captures each product `op` under a valid/ready handshake and buffers it in a 2-entry FIFO.
- Classifies each buffered result (zero/denormal/normal/inf/NaN) and counts delivered results.
- Converts the multiplier into a streaming, backpressure-capable unit for downstream consumers.

Parameters:
- DEPTH, 2: FIFO entries. Only 2 is supported.
- CNT_W, 16: width of the delivered-result counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream presents a product on in_op
- in_ready  out  1  stage can accept; high when fewer than 2 entries are held
- in_op  in  32  FP32 product from multi
- out_valid  out  1  out_data/out_class hold a valid entry
- out_ready  in  1  downstream accepts the head entry
- out_data  out  32  head entry, FP32
- out_class  out  5  one-hot class of the head entry: {nan, inf, normal, denorm, zero}
- res_count  out  CNT_W  number of results popped, wraps
- flags  out  4  sticky {nan, inf, denorm, zero}; driven to 0 when the option is absent
- flag_clr  in  1  synchronous clear of the sticky flags

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO empty: count=0, rd/wr pointers=0.
  - out_valid=0, in_ready=1, out_data=0, out_class=5'b00001, res_count=0, flags=0.
  - Reset mid-transfer discards all buffered entries.
- Push: in_valid & in_ready at a rising edge writes in_op to the tail.
- Pop: out_valid & out_ready at a rising edge advances the head and increments res_count.
- Latency and throughput:
  - An entry pushed into an empty FIFO appears on out_data/out_valid the next cycle (1-cycle latency).
  - Sustained throughput is 1 result/cycle while out_ready=1.
- in_ready depends only on registered occupancy (count!=2). It has no combinational path from out_ready.
- Occupancy transitions:
  - Simultaneous push and pop: count unchanged, data order preserved.
  - Count=2 with a pop: count becomes 1 and in_ready rises next cycle.
  - Count=0 with a pop request: no effect; out_valid stays 0.
- out_data/out_class are stable while out_valid=1 & out_ready=0 (standard hold rule).
- out_valid never drops without a pop.
- Classification, on out_data with e=[30:23], f=[22:0]:
  - zero: e=0, f=0
  - denorm: e=0, f!=0
  - inf: e=FF, f=0
  - nan: e=FF, f!=0
  - normal: otherwise
- Sign is ignored for classification.
- out_class is combinational from the head entry and is valid only while out_valid=1. When the FIFO is empty it shows the zero class.
- res_count wraps from 2^CNT_W-1 to 0 with no flag.
- Pointers are 1 bit and wrap modulo 2.

Optional Feature:
- Macro: FMUL_STICKY_FLAGS_EN.
- Defined:
  - On every pop, flags |= the class bits of the popped entry (normal excluded).
  - flag_clr=1 clears flags at the next edge.
  - If flag_clr and a pop occur in the same cycle, clear wins and the popped class is dropped.
  - Flags are cleared by reset.
- Undefined:
  - flags is tied to 4'b0000.
  - flag_clr is ignored; no flag registers are synthesized.

Test Plan:
- Reset with in_valid=1, in_op=40000000, then release rst_n -> out_valid=0, in_ready=1, res_count=0 throughout reset. Nothing is captured while rst_n=0.
- Push 3F800000 with out_ready=1 -> next cycle out_valid=1, out_data=3F800000, out_class=00100 (normal). Popped the following edge; res_count=1.
- Stream 00000000, 00000001, 7F800000, 7FC00000 with out_ready=1 -> out_class sequence 00001, 00010, 01000, 10000. res_count=4. With the macro, flags=4'b1111.
- out_ready=0, push 3F800000 then C0000000 -> in_ready=0 after the second push and out_data holds 3F800000. Raise out_ready -> outputs in order, in_ready=1 one cycle after the first pop.
- Full FIFO, in_valid=1 with out_ready=1 for 10 cycles, incrementing data -> no loss or duplication, order matches, res_count=10.
- Macro defined, flags=1111, assert flag_clr during a pop of 7FC00000 -> flags=0000 next cycle.
- Preload res_count to FFFF (CNT_W=16) via 65535 pops, then one more pop -> res_count=0000.
